uart_sample_receiver: RTL

UART_SAMPLE_RECEIVER -- requirements
Module: uart_sample_receiver

---
 rtl/uart_sample_pkg.sv | 28 ++
 rtl/uart_rx.sv | 119 +++++++++++
 rtl/uart_sample_receiver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_sample_pkg.sv
// Shared constants and state encodings for the UART sample receiver.
package uart_sample_pkg;

  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_H = 8'h48;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    WaitC,
    WaitH,
    WaitId,
    WaitMsb,
    WaitLsb
  } parse_state_e;

  // Channel expected to follow ch in a well-ordered stream.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronizes rx, finds the start edge and samples mid-bit.
module uart_rx
  import uart_sample_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(BIT_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BIT_DIV - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             fall, cnt_zero;

  // Two-flop synchronizer plus one delayed copy for edge detection, all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // A low stop bit leaves rx_prev_q low, so no new start until the line has been high.
  assign fall     = rx_prev_q & ~rx_sync_q;
  assign cnt_zero = (cnt_q == '0);

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RxIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic: count down to zero, then act on the sampled line.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (fall) begin
          state_d = RxStart;
          cnt_d   = HALF_CNT;
        end
      end
      RxStart: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_sync_q) begin
          state_d   = RxData;
          cnt_d     = FULL_CNT;
          bit_idx_d = '0;
        end else begin
          state_d = RxIdle;  // glitch, silently dropped
        end
      end
      RxData: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          cnt_d     = FULL_CNT;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RxIdle;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_sample_receiver.sv
// Decodes "CH<id><msb><lsb>" frames from a UART stream into four sample registers.
module uart_sample_receiver
  import uart_sample_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3,
  output logic               sample_valid,
  output logic [1:0]         sample_ch,
  output logic               frame_err,
  output logic               seq_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_frame_err)
  );

  parse_state_e    state_q, state_d;
  logic [1:0]      ch_q, ch_d;
  logic [7:0]      msb_q, msb_d;
  logic [3:0][15:0] sample_q, sample_d;
  logic            sample_valid_q, sample_valid_d;
  logic [1:0]      sample_ch_q, sample_ch_d;
  logic            seq_err_q, seq_err_d;
  logic [1:0]      prev_ch_q, prev_ch_d;
  logic            prev_vld_q, prev_vld_d;
  logic [7:0]      id_off;

  // Parser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= WaitC;
      ch_q           <= '0;
      msb_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      seq_err_q      <= 1'b0;
      prev_ch_q      <= '0;
      prev_vld_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      msb_q          <= msb_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      seq_err_q      <= seq_err_d;
      prev_ch_q      <= prev_ch_d;
      prev_vld_q     <= prev_vld_d;
    end
  end

  // Wraps below ASCII_0, so one compare covers the whole '0'..'3' range.
  assign id_off = byte_data - ASCII_0;

  // Frame parser; a framing error always abandons the frame in progress.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    msb_d          = msb_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    seq_err_d      = 1'b0;
    prev_ch_d      = prev_ch_q;
    prev_vld_d     = prev_vld_q;
    if (rx_frame_err) begin
      state_d = WaitC;
    end else if (byte_valid) begin
      unique case (state_q)
        WaitC: begin
          if (byte_data == ASCII_C) state_d = WaitH;
        end
        WaitH: begin
          if (byte_data == ASCII_H)      state_d = WaitId;
          else if (byte_data == ASCII_C) state_d = WaitH;
          else                           state_d = WaitC;
        end
        WaitId: begin
          if (id_off < 8'd4) begin
            ch_d    = id_off[1:0];
            state_d = WaitMsb;
          end else if (byte_data == ASCII_C) begin
            state_d = WaitH;
          end else begin
            state_d = WaitC;
          end
        end
        WaitMsb: begin
          msb_d   = byte_data;
          state_d = WaitLsb;
        end
        WaitLsb: begin
          state_d        = WaitC;
          sample_d[ch_q] = {msb_q, byte_data};
          sample_valid_d = 1'b1;
          sample_ch_d    = ch_q;
          seq_err_d      = prev_vld_q && (ch_q != next_ch(prev_ch_q));
          prev_ch_d      = ch_q;
          prev_vld_d     = 1'b1;
        end
        default: state_d = WaitC;
      endcase
    end
  end

  assign sample_out0  = sample_q[0];
  assign sample_out1  = sample_q[1];
  assign sample_out2  = sample_q[2];
  assign sample_out3  = sample_q[3];
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign seq_err      = seq_err_q;
  assign frame_err    = rx_frame_err;

endmodule
